// File: rtl/button_step_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// button_step_counter - two debounced pushbuttons with press/hold/auto-repeat
// stepping a wrap-around W-bit value up or down.            Rev 1.0
//------------------------------------------------------------------------------
module button_step_counter #(
  parameter int unsigned W             = 4,
  parameter int unsigned DB_CYCLES     = 500_000,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic         CLK1,
  input  logic         arst_n,
  input  logic         btn_up,
  input  logic         btn_dn,
  output logic [W-1:0] value,
  output logic         step_up,
  output logic         step_dn,
  output logic         held
);

  localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);
  localparam int unsigned T_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned T_W   = $clog2(T_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [1:0] btn_raw;
  logic [1:0] step_req;
  logic [1:0] in_repeat_d;

  // Index 0 is the up button, index 1 the down button.
  assign btn_raw = {btn_dn, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync1_q, sync2_q;
      logic            db_q, db_d;
      logic [DB_W-1:0] dbcnt_q, dbcnt_d;
      logic [1:0]      state_q, state_d;
      logic [T_W-1:0]  timer_q, timer_d;
      logic            req;

      always_ff @(posedge CLK1 or negedge arst_n) begin
        if (!arst_n) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          db_q    <= 1'b0;
          dbcnt_q <= '0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
          db_q    <= db_d;
          dbcnt_q <= dbcnt_d;
        end
      end

      always_comb begin
        dbcnt_d = '0;
        db_d    = db_q;
        if (sync2_q != db_q) begin
          if (dbcnt_q == DB_W'(DB_CYCLES - 1)) db_d = ~db_q;
          else                                 dbcnt_d = dbcnt_q + 1'b1;
        end
      end

      always_ff @(posedge CLK1 or negedge arst_n) begin
        if (!arst_n) begin
          state_q <= S_IDLE;
          timer_q <= '0;
        end else begin
          state_q <= state_d;
          timer_q <= timer_d;
        end
      end

      // Release always wins over a timer expiry in the same cycle.
      always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
          S_IDLE: begin
            if (db_q) begin
              state_d = S_HOLD;
              timer_d = T_W'(HOLD_CYCLES - 1);
            end
          end
          S_HOLD: begin
            if (!db_q) begin
              state_d = S_IDLE;
              timer_d = '0;
            end else if (timer_q != '0) begin
              timer_d = timer_q - 1'b1;
            end else if (REPEAT_EN) begin
              state_d = S_REPEAT;
              timer_d = T_W'(REPEAT_CYCLES - 1);
            end
          end
          S_REPEAT: begin
            if (!db_q) begin
              state_d = S_IDLE;
              timer_d = '0;
            end else if (timer_q == '0) begin
              timer_d = T_W'(REPEAT_CYCLES - 1);
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
          default: begin
            state_d = S_IDLE;
            timer_d = '0;
          end
        endcase
      end

      always_comb begin
        req = 1'b0;
        case (state_q)
          S_IDLE:   req = db_q;
          S_HOLD:   req = db_q && (timer_q == '0) && REPEAT_EN;
          S_REPEAT: req = db_q && (timer_q == '0);
          default:  req = 1'b0;
        endcase
      end

      assign step_req[gi]    = req;
      assign in_repeat_d[gi] = (state_d == S_REPEAT);
    end
  endgenerate

  logic [W-1:0] value_q, value_d;
  logic         step_up_q, step_up_d;
  logic         step_dn_q, step_dn_d;
  logic         held_q;

  // Simultaneous up and down requests cancel and are not deferred.
  always_comb begin
    value_d   = value_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    case (step_req)
      2'b01: begin
        value_d   = value_q + 1'b1;
        step_up_d = 1'b1;
      end
      2'b10: begin
        value_d   = value_q - 1'b1;
        step_dn_d = 1'b1;
      end
      default: value_d = value_q;
    endcase
  end

  always_ff @(posedge CLK1 or negedge arst_n) begin
    if (!arst_n) begin
      value_q   <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      value_q   <= value_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      held_q    <= |in_repeat_d;
    end
  end

  assign value   = value_q;
  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign held    = held_q;

endmodule
`default_nettype wire

// File: tb/tb_button_step_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_button_step_counter - randomized and directed bench against an
// event-timing reference model; two DUTs (auto-repeat on / off). Rev 1.0
//------------------------------------------------------------------------------
module tb_button_step_counter;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int RPT  = 5;
  localparam int W    = 4;

  logic         CLK1   = 1'b0;
  logic         arst_n = 1'b0;
  logic         btn_up = 1'b0;
  logic         btn_dn = 1'b0;
  logic [W-1:0] value_a, value_b;
  logic         up_a, dn_a, held_a, up_b, dn_b, held_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK1 = ~CLK1;

  button_step_counter #(.W(W), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
                        .REPEAT_CYCLES(RPT), .REPEAT_EN(1'b1)) dut (
    .CLK1(CLK1), .arst_n(arst_n), .btn_up(btn_up), .btn_dn(btn_dn),
    .value(value_a), .step_up(up_a), .step_dn(dn_a), .held(held_a));

  button_step_counter #(.W(W), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
                        .REPEAT_CYCLES(RPT), .REPEAT_EN(1'b0)) dut_nr (
    .CLK1(CLK1), .arst_n(arst_n), .btn_up(btn_up), .btn_dn(btn_dn),
    .value(value_b), .step_up(up_b), .step_dn(dn_b), .held(held_b));

  // Reference model: raw history window decides debounced level; steps are
  // predicted from the age of the current press (edges since debounced rise).
  logic [DB:0]  hist [2];
  logic         m_db [2];
  int           m_rise [2];
  int           m_n;
  logic [W-1:0] m_value [2];
  logic         m_up [2], m_dn [2], m_held [2];

  function automatic logic m_req(int b, int n, logic ren);
    int age;
    if (!m_db[b]) return 1'b0;
    age = n - m_rise[b] - 1;
    if (age == 0) return 1'b1;
    if (!ren || age < HOLD) return 1'b0;
    return ((age - HOLD) % RPT) == 0;
  endfunction

  function automatic logic m_rep(int b, int n, logic ren);
    return m_db[b] && ren && ((n - m_rise[b] - 1) >= HOLD);
  endfunction

  function automatic logic [W-1:0] m_next(int v, int n);
    logic u, d;
    u = m_req(0, n, v == 0);
    d = m_req(1, n, v == 0);
    if (u && !d) return m_value[v] + 1'b1;
    if (d && !u) return m_value[v] - 1'b1;
    return m_value[v];
  endfunction

  always @(posedge CLK1 or negedge arst_n) begin
    if (!arst_n) begin
      m_n <= 0;
      for (int b = 0; b < 2; b++) begin
        hist[b]   <= '0;
        m_db[b]   <= 1'b0;
        m_rise[b] <= 0;
        m_value[b] <= '0;
        m_up[b]   <= 1'b0;
        m_dn[b]   <= 1'b0;
        m_held[b] <= 1'b0;
      end
    end else begin
      m_n <= m_n + 1;
      for (int v = 0; v < 2; v++) begin
        m_up[v]    <= m_req(0, m_n + 1, v == 0) && !m_req(1, m_n + 1, v == 0);
        m_dn[v]    <= m_req(1, m_n + 1, v == 0) && !m_req(0, m_n + 1, v == 0);
        m_held[v]  <= m_rep(0, m_n + 1, v == 0) || m_rep(1, m_n + 1, v == 0);
        m_value[v] <= m_next(v, m_n + 1);
      end
      for (int b = 0; b < 2; b++) begin
        if (hist[b][DB:1] == {DB{~m_db[b]}}) begin
          m_db[b] <= ~m_db[b];
          if (!m_db[b]) m_rise[b] <= m_n + 1;
        end
        hist[b] <= {hist[b][DB-1:0], (b == 0) ? btn_up : btn_dn};
      end
    end
  end

  logic [13:0] obs, expv;
  assign obs  = {value_a, up_a, dn_a, held_a, value_b, up_b, dn_b, held_b};
  assign expv = {m_value[0], m_up[0], m_dn[0], m_held[0],
                 m_value[1], m_up[1], m_dn[1], m_held[1]};

  task automatic do_reset;
    @(negedge CLK1);
    arst_n = 1'b0;
    @(negedge CLK1);
    arst_n = 1'b1;
  endtask

  task automatic press(input logic u, input logic d, input int hi, input int lo,
                       output int nua, output int nda, output int nub, output int ndb);
    nua = 0; nda = 0; nub = 0; ndb = 0;
    btn_up = u;
    btn_dn = d;
    for (int i = 0; i < hi + lo; i++) begin
      @(negedge CLK1);
      if (up_a) nua++;
      if (dn_a) nda++;
      if (up_b) nub++;
      if (dn_b) ndb++;
      if (i == hi - 1) begin
        btn_up = 1'b0;
        btn_dn = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    arst_n = 1'b0;
    repeat (2) @(negedge CLK1);
    n_tests++;
    if (obs !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, 14'h0);
    end
    arst_n = 1'b1;
    repeat (5) begin
      @(negedge CLK1);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL reset_idle: got %h expected %h", obs, expv);
      end
    end
  endtask

  task automatic test_single_press;
    int first, nup;
    logic saw_held;
    first = -1; nup = 0; saw_held = 1'b0;
    btn_up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK1);
      if (up_a) begin
        nup++;
        if (first < 0) first = i;
      end
      if (held_a) saw_held = 1'b1;
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL single_model cyc %0d: got %h expected %h", i, obs, expv);
      end
      if (i == 10) btn_up = 1'b0;
    end
    n_tests++;
    if (nup !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", nup); end
    n_tests++;
    if (first !== DB + 3) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", first, DB + 3); end
    n_tests++;
    if (value_a !== 4'h1) begin n_fail++; $display("FAIL single_value: got %h expected 1", value_a); end
    n_tests++;
    if (saw_held !== 1'b0) begin n_fail++; $display("FAIL single_held: got %b expected 0", saw_held); end
  endtask

  task automatic test_glitch;
    int nua, nda, nub, ndb;
    logic [W-1:0] v0;
    v0 = value_a;
    press(1'b1, 1'b0, 3, 12, nua, nda, nub, ndb);
    n_tests++;
    if (nua !== 0 || value_a !== v0) begin
      n_fail++;
      $display("FAIL glitch_reject: steps %0d value %h expected 0 steps value %h", nua, value_a, v0);
    end
    press(1'b1, 1'b0, 4, 12, nua, nda, nub, ndb);
    n_tests++;
    if (nua !== 1 || value_a !== v0 + 4'h1) begin
      n_fail++;
      $display("FAIL glitch_accept: steps %0d value %h expected 1 steps value %h", nua, value_a, v0 + 4'h1);
    end
    n_tests++;
    if (obs !== expv) begin n_fail++; $display("FAIL glitch_model: got %h expected %h", obs, expv); end
  endtask

  task automatic test_wrap;
    int nua, nda, nub, ndb, total;
    do_reset();
    press(1'b0, 1'b1, 8, 10, nua, nda, nub, ndb);
    n_tests++;
    if (nda !== 1 || value_a !== 4'hF) begin
      n_fail++;
      $display("FAIL wrap_down: steps %0d value %h expected 1 steps value f", nda, value_a);
    end
    total = 0;
    for (int p = 0; p < 16; p++) begin
      press(1'b1, 1'b0, 8, 10, nua, nda, nub, ndb);
      total += nua;
    end
    n_tests++;
    if (total !== 16 || value_a !== 4'hF) begin
      n_fail++;
      $display("FAIL wrap_up: steps %0d value %h expected 16 steps value f", total, value_a);
    end
    n_tests++;
    if (obs !== expv) begin n_fail++; $display("FAIL wrap_model: got %h expected %h", obs, expv); end
  endtask

  task automatic test_repeat;
    int H, nua, nub, exp_a;
    int idx [$];
    logic held_at [$];
    H = 45; nua = 0; nub = 0;
    exp_a = 1 + ((H - 1 - HOLD) / RPT + 1);
    btn_up = 1'b1;
    for (int i = 1; i <= H + 15; i++) begin
      @(negedge CLK1);
      if (up_a) begin nua++; idx.push_back(i); held_at.push_back(held_a); end
      if (up_b) nub++;
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL repeat_model cyc %0d: got %h expected %h", i, obs, expv);
      end
      if (i == H) btn_up = 1'b0;
    end
    n_tests++;
    if (nua !== exp_a) begin n_fail++; $display("FAIL repeat_count: got %0d expected %0d", nua, exp_a); end
    n_tests++;
    if (nub !== 1) begin n_fail++; $display("FAIL norepeat_count: got %0d expected 1", nub); end
    if (idx.size() >= 3) begin
      n_tests++;
      if (idx[1] - idx[0] !== HOLD || held_at[1] !== 1'b1 || held_at[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL repeat_hold_gap: got %0d held %b expected %0d held 1", idx[1] - idx[0], held_at[1], HOLD);
      end
      n_tests++;
      if (idx[2] - idx[1] !== RPT) begin
        n_fail++;
        $display("FAIL repeat_period: got %0d expected %0d", idx[2] - idx[1], RPT);
      end
    end else begin
      n_tests++; n_fail++;
      $display("FAIL repeat_steps: got %0d expected at least 3", idx.size());
    end
    n_tests++;
    if (held_a !== 1'b0) begin n_fail++; $display("FAIL repeat_release: got held %b expected 0", held_a); end
  endtask

  task automatic test_both;
    int nua, nda, nub, ndb;
    logic [W-1:0] va, vb;
    va = value_a; vb = value_b;
    press(1'b1, 1'b1, 10, 10, nua, nda, nub, ndb);
    n_tests++;
    if ((nua + nda + nub + ndb) !== 0 || value_a !== va || value_b !== vb) begin
      n_fail++;
      $display("FAIL both_cancel: pulses %0d values %h/%h expected 0 pulses values %h/%h",
               nua + nda + nub + ndb, value_a, value_b, va, vb);
    end
    press(1'b1, 1'b0, 60, 12, nua, nda, nub, ndb);
    n_tests++;
    if (nub !== 1 || value_b !== vb + 4'h1) begin
      n_fail++;
      $display("FAIL norepeat_hold: steps %0d value %h expected 1 steps value %h", nub, value_b, vb + 4'h1);
    end
    n_tests++;
    if (obs !== expv) begin n_fail++; $display("FAIL both_model: got %h expected %h", obs, expv); end
  endtask

  task automatic test_reset_mid_repeat;
    int nua, nda, nub, ndb, first;
    logic found;
    do_reset();
    for (int p = 0; p < 5; p++) press(1'b1, 1'b0, 8, 10, nua, nda, nub, ndb);
    btn_up = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge CLK1);
      if (held_a) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL midrst_held_timeout: got held 0 expected 1"); end
    @(negedge CLK1);
    n_tests++;
    if (value_a !== 4'h7) begin n_fail++; $display("FAIL midrst_value: got %h expected 7", value_a); end
    arst_n = 1'b0;
    #1;
    n_tests++;
    if ({value_a, held_a, up_a, dn_a} !== 7'h0) begin
      n_fail++;
      $display("FAIL midrst_async: got %h expected 0", {value_a, held_a, up_a, dn_a});
    end
    repeat (2) @(negedge CLK1);
    arst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK1);
      if (up_a && first < 0) first = i;
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL midrst_model cyc %0d: got %h expected %h", i, obs, expv);
      end
    end
    n_tests++;
    if (first !== DB + 3) begin n_fail++; $display("FAIL midrst_latency: got %0d expected %0d", first, DB + 3); end
    btn_up = 1'b0;
    repeat (12) @(negedge CLK1);
  endtask

  task automatic test_random;
    int len;
    for (int seg = 0; seg < 50; seg++) begin
      btn_up = 1'($urandom_range(0, 1));
      btn_dn = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(7, 45);
      for (int i = 0; i < len; i++) begin
        @(negedge CLK1);
        n_tests++;
        if (obs !== expv) begin
          n_fail++;
          $display("FAIL random_model seg %0d: got %h expected %h", seg, obs, expv);
        end
      end
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_wrap();
    test_repeat();
    test_both();
    test_reset_mid_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
